// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
// Shares one byte-wide UART transmitter between two frame-oriented
// requesters. Each granted frame goes out as a header byte (HDR0 or HDR1
// naming the channel) followed by the channel's bytes, up to and including
// the one flagged last. A frame is never interrupted by the other channel.
//
// Ports
//   clk                    system clock, rising edge
//   reset                  synchronous, active-high
//   req0_valid/req1_valid  requester has a byte available
//   req0_data/req1_data    requester byte
//   req0_last/req1_last    byte is the final byte of its frame
//   req0_ready/req1_ready  combinational; byte moves when valid && ready
//   uart_active            transmitter busy (rises the cycle after uart_dv)
//   uart_dv                registered one-cycle start pulse to transmitter
//   uart_d                 registered byte to transmitter
//   grant                  registered one-hot owner, 2'b00 when idle
//   frames_sent            registered count of completed frames (wraps)
module uart_frame_arbiter #(
  parameter logic [7:0] HDR0 = 8'hA0,
  parameter logic [7:0] HDR1 = 8'hA1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  input  logic        req0_last,
  input  logic        req1_last,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        uart_active,
  output logic        uart_dv,
  output logic [7:0]  uart_d,
  output logic [1:0]  grant,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;

  state_t     state;
  logic [1:0] holdoff;
  logic       last_owner;
  logic       frame_done;
  logic       issue_ok;

  // uart_active only rises a cycle after our pulse, so the holdoff counter
  // keeps us from trusting a stale "not busy" in that window.
  assign issue_ok   = (holdoff == 2'd0) && !uart_active;
  assign req0_ready = (state == DATA) && grant[0] && issue_ok;
  assign req1_ready = (state == DATA) && grant[1] && issue_ok;

  // last_owner is 1 for channel 1, so after reset a tie goes to channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      uart_dv     <= 1'b0;
      uart_d      <= 8'h00;
      frames_sent <= 16'h0000;
      holdoff     <= 2'd0;
      last_owner  <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      uart_dv <= 1'b0;
      if (holdoff != 2'd0) begin
        holdoff <= holdoff - 2'd1;
      end

      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            grant <= last_owner ? 2'b01 : 2'b10;
            state <= HDR;
          end else if (req0_valid) begin
            grant <= 2'b01;
            state <= HDR;
          end else if (req1_valid) begin
            grant <= 2'b10;
            state <= HDR;
          end
        end

        HDR: begin
          if (issue_ok) begin
            uart_d     <= grant[1] ? HDR1 : HDR0;
            uart_dv    <= 1'b1;
            holdoff    <= 2'd2;
            frame_done <= 1'b0;
            state      <= HOLD;
          end
        end

        // Only the granted channel can see ready, so at most one branch fires.
        DATA: begin
          if (req0_valid && req0_ready) begin
            uart_d     <= req0_data;
            uart_dv    <= 1'b1;
            holdoff    <= 2'd2;
            frame_done <= req0_last;
            state      <= HOLD;
          end else if (req1_valid && req1_ready) begin
            uart_d     <= req1_data;
            uart_dv    <= 1'b1;
            holdoff    <= 2'd2;
            frame_done <= req1_last;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (holdoff == 2'd0) begin
            if (!frame_done) begin
              state <= DATA;
            end else begin
              frames_sent <= frames_sent + 16'd1;
              last_owner  <= grant[1];
              grant       <= 2'b00;
              state       <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Self-checking bench for uart_frame_arbiter: queue-fed requesters, a UART
// busy model, a timestamp-based reference model compared every cycle, and
// directed frame scenarios with literal expected byte sequences.
module tb_uart_frame_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } item_t;
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic [7:0]  req_data [2];
  logic        req_last [2];
  logic        req_ready [2];
  logic        uart_active;
  logic        uart_dv;
  logic [7:0]  uart_d;
  logic [1:0]  grant;
  logic [15:0] frames_sent;

  item_t   chan_q [2][$];
  byte_q_t log_q;
  int      checks = 0;
  int      errors = 0;
  bit      check_en = 0;
  logic    prev_dv = 1'b0;
  int      busy_len = 10;
  int      busy_cnt = 0;

  uart_frame_arbiter #(.HDR0(8'hA0), .HDR1(8'hA1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
    .req0_data(req_data[0]),   .req1_data(req_data[1]),
    .req0_last(req_last[0]),   .req1_last(req_last[1]),
    .req0_ready(req_ready[0]), .req1_ready(req_ready[1]),
    .uart_active(uart_active), .uart_dv(uart_dv), .uart_d(uart_d),
    .grant(grant), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // Transmitter: a start pulse makes it busy for busy_len cycles, starting
  // the cycle after the pulse.
  always @(posedge clk) begin
    if (uart_dv === 1'b1) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_active = (busy_cnt != 0);

  // Reference model. A start pulse at edge E occupies the block for edges
  // E+1..E+3; the next issue can happen no earlier than edge E+4, and a
  // frame whose last byte went out at E is counted at edge E+3.
  int          m_edge = 0;
  int          m_issue_edge = 0;
  int          m_owner = -1;
  int          m_prev_owner = 1;
  bit          m_hdr_done = 0;
  bit          m_in_flight = 0;
  bit          m_final = 0;
  logic [15:0] m_frames = 16'h0;
  logic        m_dv = 1'b0;
  logic [7:0]  m_d = 8'h00;

  always @(posedge clk) begin
    m_edge <= m_edge + 1;
    m_dv   <= 1'b0;
    if (reset) begin
      m_owner      <= -1;
      m_prev_owner <= 1;
      m_in_flight  <= 0;
      m_hdr_done   <= 0;
      m_frames     <= 16'h0;
      m_d          <= 8'h00;
    end else if (m_in_flight) begin
      if (m_edge == m_issue_edge + 3) begin
        m_in_flight <= 0;
        if (m_final) begin
          m_frames     <= m_frames + 16'd1;
          m_prev_owner <= m_owner;
          m_owner      <= -1;
        end
      end
    end else if (m_owner < 0) begin
      m_hdr_done <= 0;
      if (req_valid[0] && req_valid[1]) m_owner <= (m_prev_owner == 1) ? 0 : 1;
      else if (req_valid[0]) m_owner <= 0;
      else if (req_valid[1]) m_owner <= 1;
    end else if (!uart_active) begin
      if (!m_hdr_done) begin
        m_d          <= (m_owner == 1) ? 8'hA1 : 8'hA0;
        m_dv         <= 1'b1;
        m_hdr_done   <= 1;
        m_final      <= 0;
        m_in_flight  <= 1;
        m_issue_edge <= m_edge;
      end else if (req_valid[m_owner]) begin
        m_d          <= req_data[m_owner];
        m_dv         <= 1'b1;
        m_final      <= req_last[m_owner];
        m_in_flight  <= 1;
        m_issue_edge <= m_edge;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (uart_dv === 1'b1) log_q.push_back(uart_d);
    prev_dv <= uart_dv;
    if (check_en) begin
      checkOutput("grant", {14'h0, grant},
                  (m_owner < 0) ? 16'h0 : ((m_owner == 0) ? 16'h1 : 16'h2));
      checkOutput("uart_dv", {15'h0, uart_dv}, {15'h0, m_dv});
      checkOutput("uart_d", {8'h0, uart_d}, {8'h0, m_d});
      checkOutput("frames_sent", frames_sent, m_frames);
      checkOutput("req0_ready", {15'h0, req_ready[0]},
                  {15'h0, (m_owner == 0 && m_hdr_done && !m_in_flight && !uart_active)});
      checkOutput("req1_ready", {15'h0, req_ready[1]},
                  {15'h0, (m_owner == 1 && m_hdr_done && !m_in_flight && !uart_active)});
      checkOutput("dv_while_active", {15'h0, uart_dv && uart_active}, 16'h0);
      checkOutput("dv_back_to_back", {15'h0, uart_dv && prev_dv}, 16'h0);
      checkOutput("ready_in_holdoff",
                  {15'h0, (req_ready[0] || req_ready[1]) && (dut.holdoff != 2'd0)}, 16'h0);
    end
  end

  // Requester: presents the head of its queue; a head's gap is the number of
  // cycles valid stays low after the previous byte of that queue transferred.
  task automatic producer(input int ch);
    int waited = 0;
    bit fire;
    forever begin
      if (chan_q[ch].size() > 0 && waited >= chan_q[ch][0].gap) begin
        req_valid[ch] = 1'b1;
        req_data[ch]  = chan_q[ch][0].data;
        req_last[ch]  = chan_q[ch][0].last;
      end else begin
        req_valid[ch] = 1'b0;
        req_data[ch]  = 8'($urandom_range(0, 255));
        req_last[ch]  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      fire = req_valid[ch] && req_ready[ch] && !reset;
      @(posedge clk);
      #2;
      if (fire) begin
        void'(chan_q[ch].pop_front());
        waited = 0;
      end else begin
        waited++;
      end
    end
  endtask

  initial fork
    producer(0);
    producer(1);
  join

  task automatic applyStimulus(input int ch, input logic [7:0] data,
                               input logic last, input int gap);
    item_t it;
    it.data = data;
    it.last = last;
    it.gap  = gap;
    chan_q[ch].push_back(it);
  endtask

  task automatic push_random_frame(input int ch);
    int len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++)
      applyStimulus(ch, 8'($urandom_range(0, 255)), (i == len - 1),
                    (i == 0) ? 0 : $urandom_range(0, 4));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(chan_q[0].size() == 0 && chan_q[1].size() == 0 &&
             m_owner < 0 && !m_in_flight) && n < 5000) begin
      @(posedge clk);
      #3;
      n++;
    end
    checkOutput({name, "_timeout"}, {15'h0, n >= 5000}, 16'h0);
  endtask

  task automatic wait_log(input int count, input string name);
    int n = 0;
    while (log_q.size() < count && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    checkOutput({name, "_timeout"}, {15'h0, n >= 2000}, 16'h0);
  endtask

  task automatic check_log(input string name, input byte_q_t exp);
    checkOutput({name, "_len"}, 16'(log_q.size()), 16'(exp.size()));
    foreach (exp[i])
      checkOutput(name, (i < log_q.size()) ? {8'h0, log_q[i]} : 16'hFFFF, {8'h0, exp[i]});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    chan_q[0].delete();
    chan_q[1].delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    @(negedge clk);
    checkOutput({name, "_grant"}, {14'h0, grant}, 16'h0);
    checkOutput({name, "_dv"}, {15'h0, uart_dv}, 16'h0);
    checkOutput({name, "_d"}, {8'h0, uart_d}, 16'h0);
    checkOutput({name, "_frames"}, frames_sent, 16'h0);
    checkOutput({name, "_ready0"}, {15'h0, req_ready[0]}, 16'h0);
    checkOutput({name, "_ready1"}, {15'h0, req_ready[1]}, 16'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t     exp_q;
    logic [15:0] exp_frames;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1;
    check_reset_values("reset_init");
    @(posedge clk);
    #3;
    reset = 1'b0;

    $display("[TB] single frame on channel 0");
    log_q.delete();
    applyStimulus(0, 8'h11, 1'b0, 0);
    applyStimulus(0, 8'h22, 1'b0, 0);
    applyStimulus(0, 8'h33, 1'b1, 0);
    wait_idle("single");
    exp_q = {8'hA0, 8'h11, 8'h22, 8'h33};
    check_log("single_log", exp_q);
    checkOutput("single_frames", frames_sent, 16'd1);
    checkOutput("single_grant", {14'h0, grant}, 16'h0);

    $display("[TB] contention after reset");
    do_reset();
    log_q.delete();
    applyStimulus(0, 8'h01, 1'b0, 0);
    applyStimulus(0, 8'h02, 1'b1, 0);
    applyStimulus(1, 8'h03, 1'b0, 0);
    applyStimulus(1, 8'h04, 1'b1, 0);
    wait_idle("tie1");
    applyStimulus(0, 8'h05, 1'b1, 0);
    applyStimulus(1, 8'h06, 1'b1, 0);
    wait_idle("tie2");
    exp_q = {8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04, 8'hA0, 8'h05, 8'hA1, 8'h06};
    check_log("tie_log", exp_q);
    checkOutput("tie_frames", frames_sent, 16'd4);

    $display("[TB] no interleave");
    log_q.delete();
    applyStimulus(0, 8'h31, 1'b0, 0);
    applyStimulus(0, 8'h32, 1'b0, 0);
    applyStimulus(0, 8'h33, 1'b0, 0);
    applyStimulus(0, 8'h34, 1'b1, 0);
    wait_log(2, "noil_start");
    applyStimulus(1, 8'h41, 1'b0, 0);
    applyStimulus(1, 8'h42, 1'b1, 0);
    wait_idle("noil");
    exp_q = {8'hA0, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA1, 8'h41, 8'h42};
    check_log("noil_log", exp_q);
    checkOutput("noil_frames", frames_sent, 16'd6);

    $display("[TB] mid-frame gap");
    log_q.delete();
    applyStimulus(0, 8'h51, 1'b0, 0);
    applyStimulus(0, 8'h52, 1'b0, 50);
    applyStimulus(0, 8'h53, 1'b1, 0);
    wait_idle("gap");
    exp_q = {8'hA0, 8'h51, 8'h52, 8'h53};
    check_log("gap_log", exp_q);
    checkOutput("gap_frames", frames_sent, 16'd7);

    $display("[TB] reset mid-frame");
    log_q.delete();
    applyStimulus(1, 8'h61, 1'b0, 0);
    applyStimulus(1, 8'h62, 1'b0, 0);
    applyStimulus(1, 8'h63, 1'b1, 0);
    wait_log(1, "rst_hdr");
    do_reset();
    check_reset_values("reset_mid");
    exp_q = {8'hA1};
    check_log("rst_log", exp_q);
    log_q.delete();
    applyStimulus(0, 8'h71, 1'b1, 0);
    applyStimulus(1, 8'h72, 1'b1, 0);
    wait_idle("rst_tie");
    exp_q = {8'hA0, 8'h71, 8'hA1, 8'h72};
    check_log("rst_tie_log", exp_q);
    checkOutput("rst_tie_frames", frames_sent, 16'd2);

    $display("[TB] randomized traffic");
    exp_frames = 16'd2;
    for (int it = 0; it < 25; it++) begin
      busy_len = $urandom_range(1, 12);
      if ($urandom_range(0, 3) != 0) begin
        push_random_frame(0);
        exp_frames++;
      end
      repeat ($urandom_range(0, 20)) begin
        @(posedge clk);
        #3;
      end
      if ($urandom_range(0, 3) != 0) begin
        push_random_frame(1);
        exp_frames++;
      end
      if ($urandom_range(0, 1) != 0) begin
        push_random_frame(0);
        exp_frames++;
      end
      wait_idle("random");
    end
    checkOutput("random_frames", frames_sent, exp_frames);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
